// File: rtl/propagate_literal_param.sv
// rtl/propagate_literal_param.sv - one-literal unit propagation over a CNF formula, one clause per cycle
// Optional unit-literal extraction is enabled by defining PL_UNIT_OUT_EN.
module propagate_literal_param #(
  parameter int VAR_W       = 3,
  parameter int MAX_LITS    = 5,
  parameter int MAX_CLAUSES = 10,
  localparam int LIT_W  = VAR_W + 1,
  localparam int LCNT_W = $clog2(MAX_LITS + 1),
  localparam int CCNT_W = $clog2(MAX_CLAUSES + 1),
  localparam int CLS_W  = MAX_LITS * LIT_W + LCNT_W,
  localparam int FRM_W  = MAX_CLAUSES * CLS_W + CCNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               find,
  input  logic [LIT_W-1:0]   in_lit,
  input  logic [FRM_W-1:0]   in_formula,
  output logic               ended,
  output logic               empty_clause,
  output logic               empty_formula,
  output logic [FRM_W-1:0]   out_formula,
  output logic               unit_found,
  output logic [LIT_W-1:0]   unit_lit
);

  localparam int BODY_W = FRM_W - CCNT_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LIT_W-1:0]    lit_q, lit_d;
  logic [BODY_W-1:0]   cls_q, cls_d;
  logic [CCNT_W-1:0]   n_q, n_d;
  logic [CCNT_W-1:0]   k_q, k_d;
  logic [CCNT_W-1:0]   wptr_q, wptr_d;
  logic [FRM_W-1:0]    out_q, out_d;
  logic                ended_q, ended_d;
  logic                ec_q, ec_d;
  logic                ef_q, ef_d;

`ifdef PL_UNIT_OUT_EN
  logic                uf_q, uf_d;
  logic [LIT_W-1:0]    ul_q, ul_d;
  logic                seen_q, seen_d;
  logic [LIT_W-1:0]    cand_q, cand_d;
`endif

  logic [CLS_W-1:0]    cur_cls, new_cls;
  logic [LCNT_W-1:0]   cur_cnt, new_cnt;
  logic                cur_sat;
  logic [LIT_W-1:0]    slot;
  logic                hit_var;
  logic [CCNT_W-1:0]   in_cnt;

  // Clause datapath: satisfaction test plus deletion/compaction of the current clause
  always_comb begin
    cur_cls = cls_q[int'(k_q) * CLS_W +: CLS_W];
    cur_cnt = cur_cls[LCNT_W-1:0];
    if (cur_cnt > LCNT_W'(MAX_LITS)) cur_cnt = LCNT_W'(MAX_LITS);
    cur_sat = 1'b0;
    new_cls = '0;
    new_cnt = '0;
    slot    = '0;
    hit_var = 1'b0;
    for (int j = 0; j < MAX_LITS; j++) begin
      slot    = cur_cls[LCNT_W + j * LIT_W +: LIT_W];
      hit_var = (lit_q[LIT_W-1:1] != '0) && (slot[LIT_W-1:1] == lit_q[LIT_W-1:1]);
      if (j < int'(cur_cnt)) begin
        if (hit_var && (slot[0] == lit_q[0])) cur_sat = 1'b1;
        if (!(hit_var && (slot[0] != lit_q[0]))) begin
          new_cls[LCNT_W + int'(new_cnt) * LIT_W +: LIT_W] = slot;
          new_cnt = new_cnt + LCNT_W'(1);
        end
      end
    end
    new_cls[LCNT_W-1:0] = new_cnt;
  end

  always_comb begin
    in_cnt = in_formula[CCNT_W-1:0];
    if (in_cnt > CCNT_W'(MAX_CLAUSES)) in_cnt = CCNT_W'(MAX_CLAUSES);
  end

  always_comb begin
    state_d = state_q;
    lit_d   = lit_q;
    cls_d   = cls_q;
    n_d     = n_q;
    k_d     = k_q;
    wptr_d  = wptr_q;
    out_d   = out_q;
    ended_d = ended_q;
    ec_d    = ec_q;
    ef_d    = ef_q;
`ifdef PL_UNIT_OUT_EN
    uf_d    = uf_q;
    ul_d    = ul_q;
    seen_d  = seen_q;
    cand_d  = cand_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (find) begin
          lit_d   = in_lit;
          cls_d   = in_formula[FRM_W-1:CCNT_W];
          n_d     = in_cnt;
          k_d     = '0;
          wptr_d  = '0;
          out_d   = '0;
          ended_d = 1'b0;
          ec_d    = 1'b0;
          ef_d    = 1'b0;
`ifdef PL_UNIT_OUT_EN
          uf_d    = 1'b0;
          ul_d    = '0;
          seen_d  = 1'b0;
          cand_d  = '0;
`endif
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if ((k_q < n_q) && !cur_sat) begin
          out_d[CCNT_W + int'(wptr_q) * CLS_W +: CLS_W] = new_cls;
          wptr_d = wptr_q + CCNT_W'(1);
          if (new_cnt == '0) ec_d = 1'b1;
`ifdef PL_UNIT_OUT_EN
          if (!seen_q && (new_cnt == LCNT_W'(1))) begin
            seen_d = 1'b1;
            cand_d = new_cls[LCNT_W +: LIT_W];
          end
`endif
        end
        // k_q never exceeds MAX_CLAUSES-1, so k_q+1 cannot wrap; N=0 exits on the first cycle
        k_d = k_q + CCNT_W'(1);
        if (k_d >= n_q) state_d = S_DONE;
      end
      S_DONE: begin
        out_d[CCNT_W-1:0] = wptr_q;
        ef_d    = (wptr_q == '0);
        ended_d = 1'b1;
`ifdef PL_UNIT_OUT_EN
        uf_d    = seen_q;
        ul_d    = cand_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lit_q   <= '0;
      cls_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      wptr_q  <= '0;
      out_q   <= '0;
      ended_q <= 1'b0;
      ec_q    <= 1'b0;
      ef_q    <= 1'b0;
`ifdef PL_UNIT_OUT_EN
      uf_q    <= 1'b0;
      ul_q    <= '0;
      seen_q  <= 1'b0;
      cand_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lit_q   <= lit_d;
      cls_q   <= cls_d;
      n_q     <= n_d;
      k_q     <= k_d;
      wptr_q  <= wptr_d;
      out_q   <= out_d;
      ended_q <= ended_d;
      ec_q    <= ec_d;
      ef_q    <= ef_d;
`ifdef PL_UNIT_OUT_EN
      uf_q    <= uf_d;
      ul_q    <= ul_d;
      seen_q  <= seen_d;
      cand_q  <= cand_d;
`endif
    end
  end

  assign ended         = ended_q;
  assign empty_clause  = ec_q;
  assign empty_formula = ef_q;
  assign out_formula   = out_q;

`ifdef PL_UNIT_OUT_EN
  assign unit_found = uf_q;
  assign unit_lit   = ul_q;
`else
  assign unit_found = 1'b0;
  assign unit_lit   = '0;
`endif

endmodule
